// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit: accepts one issued entry per cycle, shift-and-add over STAGES stages.
// Latency: an entry accepted at an edge is visible on done_* STAGES cycles later (plus stalled cycles).
// Backpressure: an ungranted result freezes the whole pipe and drops issue_ready combinationally.
module mult_fu #(
  parameter int STAGES        = 4,
  parameter int ROB_TAG_WIDTH = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [ROB_TAG_WIDTH-1:0] issue_rob_tag,
  input  logic [31:0]              issue_opa,
  input  logic [31:0]              issue_opb,
  input  logic [1:0]               issue_func,
  output logic                     done_valid,
  output logic [ROB_TAG_WIDTH-1:0] done_rob_tag,
  output logic [31:0]              done_value,
  input  logic                     cdb_gnt
);

  // Multiplier bits consumed per stage; the mask selects the low STEP bits of the multiplier.
  localparam int          STEP     = 64 / STAGES;
  localparam logic [63:0] LOW_MASK = (STAGES == 1) ? {64{1'b1}} : ((64'd1 << STEP) - 64'd1);

  localparam logic [1:0] FUNC_MUL    = 2'd0;
  localparam logic [1:0] FUNC_MULH   = 2'd1;
  localparam logic [1:0] FUNC_MULHSU = 2'd2;

  // Per-stage state; index 0 is stage 1, index STAGES-1 is the final stage.
  logic [STAGES-1:0]        vld_q;
  logic [ROB_TAG_WIDTH-1:0] tag_q    [STAGES];
  logic [1:0]               func_q   [STAGES];
  logic [63:0]              mcand_q  [STAGES];
  logic [63:0]              mplier_q [STAGES];
  logic [63:0]              sum_q    [STAGES];

  // Inputs to each stage's step and the results it loads into its register.
  logic [63:0] src_mcand  [STAGES];
  logic [63:0] src_mplier [STAGES];
  logic [63:0] src_sum    [STAGES];
  logic [63:0] nxt_mcand  [STAGES];
  logic [63:0] nxt_mplier [STAGES];
  logic [63:0] nxt_sum    [STAGES];

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic        stall;

  assign stall       = done_valid && !cdb_gnt;
  assign issue_ready = !stall;

  // Extend operands at accept: opa signed for MULH/MULHSU, opb signed for MULH only.
  always_comb begin
    ext_a = {32'd0, issue_opa};
    ext_b = {32'd0, issue_opb};
    if (issue_func == FUNC_MULH || issue_func == FUNC_MULHSU) begin
      ext_a = {{32{issue_opa[31]}}, issue_opa};
    end
    if (issue_func == FUNC_MULH) begin
      ext_b = {{32{issue_opb[31]}}, issue_opb};
    end
  end

  // One shift-and-add step per stage: add mcand * low multiplier bits, then shift both operands.
  always_comb begin
    src_mcand[0]  = ext_a;
    src_mplier[0] = ext_b;
    src_sum[0]    = 64'd0;
    for (int k = 1; k < STAGES; k++) begin
      src_mcand[k]  = mcand_q[k-1];
      src_mplier[k] = mplier_q[k-1];
      src_sum[k]    = sum_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      nxt_sum[k]    = src_sum[k] + src_mcand[k] * (src_mplier[k] & LOW_MASK);
      nxt_mcand[k]  = src_mcand[k] << STEP;
      nxt_mplier[k] = src_mplier[k] >> STEP;
    end
  end

  // Valid bits: reset and squash clear everything; otherwise shift in the accepted entry unless stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
    end else if (squash) begin
      vld_q <= '0;
    end else if (!stall) begin
      vld_q[0] <= issue_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  // Data registers advance with the pipe; contents behind a cleared valid bit are don't-care.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        tag_q[k]    <= '0;
        func_q[k]   <= '0;
        mcand_q[k]  <= '0;
        mplier_q[k] <= '0;
        sum_q[k]    <= '0;
      end
    end else if (!stall) begin
      tag_q[0]  <= issue_rob_tag;
      func_q[0] <= issue_func;
      for (int k = 1; k < STAGES; k++) begin
        tag_q[k]  <= tag_q[k-1];
        func_q[k] <= func_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        mcand_q[k]  <= nxt_mcand[k];
        mplier_q[k] <= nxt_mplier[k];
        sum_q[k]    <= nxt_sum[k];
      end
    end
  end

  // Final stage drives the CDB; the high half serves all three MULH variants.
  always_comb begin
    done_valid   = vld_q[STAGES-1];
    done_rob_tag = tag_q[STAGES-1];
    done_value   = (func_q[STAGES-1] == FUNC_MUL) ? sum_q[STAGES-1][31:0] : sum_q[STAGES-1][63:32];
  end

endmodule

// File: doc/mult_fu.md
# mult_fu

Pipelined integer multiply functional unit sitting directly downstream of the reservation station. It accepts one issued multiply entry per cycle (operands already resolved, ROB tag attached), computes the RV32M product over a fixed number of pipeline stages, and presents the result with its ROB tag to the CDB arbiter. It then holds the result until the CDB grants it. Backpressure from the CDB stalls the whole pipeline and is reflected to the RS through `issue_ready`.

## Interface
- `STAGES`, default 4: pipeline depth; legal values are 1, 2, 4, 8. Each stage consumes 64/STAGES multiplier bits.
- `ROB_TAG_WIDTH`, default 5: width of ROB tags.
- `clock`  in  1: sole clock; all state is on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `squash`  in  1: synchronous flush; kills everything in flight.
- `issue_valid`  in  1: RS presents a ready multiply entry.
- `issue_ready`  out  1: unit can accept this cycle.
- `issue_rob_tag`  in  ROB_TAG_WIDTH: destination ROB tag.
- `issue_opa`  in  32: rs1 value (multiplicand).
- `issue_opb`  in  32: rs2 value (multiplier).
- `issue_func`  in  2: 0 = MUL, 1 = MULH, 2 = MULHSU, 3 = MULHU.
- `done_valid`  out  1: result available for CDB.
- `done_rob_tag`  out  ROB_TAG_WIDTH: tag of the result.
- `done_value`  out  32: result value.
- `cdb_gnt`  in  1: CDB accepts the result this cycle.

## Operation
- **Accept.** An entry is accepted at a rising edge when `issue_valid && issue_ready && !squash`.
- **Operand extension at accept.** Both operands are extended to 64 bits:
  - opa is sign-extended for MULH and MULHSU, and zero-extended otherwise.
  - opb is sign-extended for MULH only.
  - func and tag are captured alongside the operands.
- **Per-stage work.** Stage k (k = 1..STAGES) holds: valid, tag, func, the 64-bit multiplicand, the 64-bit multiplier, and a 64-bit partial sum.
  - Each stage adds `multiplicand × multiplier[(64/STAGES)-1:0]` to the sum (mod 2^64).
  - It then shifts the multiplicand left and the multiplier right by 64/STAGES, for the next stage.
- **Result select** (from the final stage's sum): MUL returns sum[31:0]; MULH, MULHSU and MULHU return sum[63:32].
- **Stall.** `stall = done_valid && !cdb_gnt`.
  - While stalled, every stage holds its contents and `issue_ready = 0`.
  - There is no bubble collapsing; the whole pipe freezes.
- **Advance.** When not stalled, every stage advances by one. Stage 1 loads the accepted entry, or becomes invalid if nothing is accepted.
- **Hold.** `done_valid`, `done_rob_tag` and `done_value` are driven from final-stage registers. They stay stable while stalled.
- **`issue_ready = !stall`.** The value is combinational. With `cdb_gnt` held high, the unit sustains one multiply per cycle.
- **Squash.**
  - At the rising edge with `squash = 1`, all stage valid bits clear.
  - An issue presented in the same cycle is dropped.
  - A result granted in the same cycle is still considered delivered by the CDB; the unit does nothing extra.
- **Reset.** Asynchronous assertion clears all valid bits immediately, mid-operation included. Data registers may also clear to 0.

## Timing
- **Reset values:** `done_valid = 0`, `done_rob_tag = 0`, `done_value = 0`, `issue_ready = 1`.
- **Latency.** An entry accepted at the edge ending cycle 0 appears with `done_valid = 1` during cycle STAGES, when there are no stalls. Each stalled cycle adds one cycle.
- **Retirement.** A result retires at the edge where `done_valid && cdb_gnt`.
  - The next entry (if any) appears in the following cycle.
  - `cdb_gnt` while `done_valid = 0` is ignored.
- **Throughput:** one result per cycle when granted every cycle.
- **Simultaneous grant and accept.** Grant and accept in the same cycle are legal; both take effect at that edge.
- **Priority:** reset > squash > stall/advance.

## Test plan
- **Single MUL.** Issue MUL 7×6, tag 3, with `cdb_gnt` held at 1 → `done_valid` is high exactly in cycle 4 (STAGES = 4), with value 42 and tag 3, then low.
- **Signed/unsigned high halves.**
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MUL 0x80000000×2 → 0x00000000.
- **Back-to-back.** Issue 4 consecutive multiplies (tags 1–4) with grant held at 1 → results arrive in cycles 4–7 in tag order; `issue_ready` never drops.
- **CDB backpressure.** Hold `cdb_gnt = 0` for 3 cycles once the first result appears → `issue_ready = 0`, all outputs stable for 3 cycles, no entry lost or duplicated after the grant returns.
- **Squash mid-flight.** Issue 3 entries, then assert `squash` in cycle 2 together with a new issue → `done_valid` never asserts for any of the 4; `issue_ready = 1` afterward.
- **Reset mid-operation.** Assert `reset` asynchronously between edges with a stalled valid result → `done_valid` drops before the next edge; after release, a fresh MUL 5×5 returns 25 with normal latency.
